// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared state encoding and default sizes for the shift-add MAC controller.
package mac_seq_pkg;
  typedef enum logic [1:0] {IDLE, ITER, ACC, DONE} mac_state_t;
  localparam int MAC_WIDTH = 8;
  localparam int MAC_ACC_W = 20;
  localparam int MAC_CNT_W = $clog2(MAC_WIDTH);
endpackage

// File: rtl/mac_seq_if.sv
// mac_seq_if: control, operand and result bundle between the pin wrapper and the MAC controller.
interface mac_seq_if import mac_seq_pkg::*; #(
  parameter int WIDTH = MAC_WIDTH,
  parameter int ACC_W = MAC_ACC_W
);
  logic             start;
  logic             accumulate;
  logic             clr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic             ovf;
  modport master(output start, accumulate, clr, op_a, op_b, input busy, done, result, ovf);
  modport slave(input start, accumulate, clr, op_a, op_b, output busy, done, result, ovf);
endinterface

// File: rtl/mac_seq_adder.sv
// mac_seq_adder: the single WIDTH-bit adder with carry-out shared by every multiply iteration.
module mac_seq_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o
);
  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequential shift-add multiplier feeding a sticky-overflow accumulator.
// Define MAC_SEQ_SIGNED_EN for two's-complement operands and signed overflow detection.
module mac_seq_ctrl import mac_seq_pkg::*; #(
  parameter int WIDTH = MAC_WIDTH,
  parameter int ACC_W = MAC_ACC_W
) (
  input logic     clk,
  input logic     rst,
  mac_seq_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  mac_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, add_s, mag_a, mag_b;
  logic [2*WIDTH-1:0] pp_q, pp_d;
  logic [ACC_W-1:0] result_q, result_d, prod;
  logic acc_q, acc_d, ovf_q, ovf_d, add_c, acc_ovf;
`ifdef MAC_SEQ_SIGNED_EN
  logic neg_q, neg_d;
  logic [ACC_W-1:0] sum;
  assign mag_a = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
  assign mag_b = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
  assign neg_d = state_q == IDLE ? bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1] : neg_q;
  assign prod = neg_q ? -ACC_W'(pp_q) : ACC_W'(pp_q);
  assign sum = result_q + prod;
  assign acc_ovf = (result_q[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != result_q[ACC_W-1]);
`else
  logic [ACC_W:0] sum;
  assign mag_a = bus.op_a;
  assign mag_b = bus.op_b;
  assign prod = ACC_W'(pp_q);
  assign sum = {1'b0, result_q} + {1'b0, prod};
  assign acc_ovf = sum[ACC_W];
`endif
  mac_seq_adder #(.WIDTH(WIDTH)) u_add (
    .a_i (pp_q[2*WIDTH-1:WIDTH]),
    .b_i (pp_q[0] ? mcand_q : '0),
    .s_o (add_s),
    .co_o(add_c)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    pp_d = pp_q;
    acc_d = acc_q;
    result_d = result_q;
    ovf_d = ovf_q;
    unique case (state_q)
      IDLE: begin
        result_d = bus.clr ? '0 : result_q;
        ovf_d = bus.clr ? 1'b0 : ovf_q;
        if (bus.start) begin
          state_d = ITER;
          cnt_d = '0;
          mcand_d = mag_a;
          pp_d = {{WIDTH{1'b0}}, mag_b};
          acc_d = bus.accumulate;
        end
      end
      ITER: begin
        // carry lands in the MSB as the whole {carry, partial, multiplier} shifts right
        pp_d = {add_c, add_s, pp_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? ACC : ITER;
      end
      ACC: begin
        result_d = acc_q ? sum[ACC_W-1:0] : prod;
        ovf_d = ovf_q | (acc_q & acc_ovf);
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      pp_q <= '0;
      acc_q <= 1'b0;
      result_q <= '0;
      ovf_q <= 1'b0;
`ifdef MAC_SEQ_SIGNED_EN
      neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      pp_q <= pp_d;
      acc_q <= acc_d;
      result_q <= result_d;
      ovf_q <= ovf_d;
`ifdef MAC_SEQ_SIGNED_EN
      neg_q <= neg_d;
`endif
    end
  end
  assign bus.busy = state_q == ITER || state_q == ACC;
  assign bus.done = state_q == DONE;
  assign bus.result = result_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: randomized self-checking bench against an arithmetic accumulator model.
module tb_mac_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mac_seq_if #(.WIDTH(8), .ACC_W(20)) bus();
  mac_seq_ctrl #(.WIDTH(8), .ACC_W(20)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [19:0] m_r;
  logic m_o;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic acc, input logic clr_w);
    longint p, s;
    if (clr_w) begin
      m_r = '0;
      m_o = 1'b0;
    end
`ifdef MAC_SEQ_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
    s = acc ? longint'($signed(m_r)) + p : p;
    if (acc && (s < -(64'sd1 << 19) || s >= (64'sd1 << 19))) m_o = 1'b1;
`else
    p = longint'(a) * longint'(b);
    s = acc ? longint'(m_r) + p : p;
    if (s >= (64'sd1 << 20)) m_o = 1'b1;
`endif
    m_r = s[19:0];
  endtask
  task automatic watch_no_done(input string tag);
    int nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check(tag, nd, 0);
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic acc, input logic clr_w, input logic noise);
    int n = 1;
    int nb = 0;
    logic [31:0] r = $urandom();
    @(negedge clk);
    bus.start = 1'b1;
    bus.accumulate = acc;
    bus.op_a = a;
    bus.op_b = b;
    bus.clr = clr_w;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clr = 1'b0;
    while (!bus.done && n < 20) begin
      if (bus.busy) nb++;
      if (noise && n == 3) begin
        bus.start = 1'b1;
        bus.clr = 1'b1;
        bus.op_a = r[7:0];
        bus.op_b = r[15:8];
      end
      if (noise && n == 4) begin
        bus.start = 1'b0;
        bus.clr = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    model(a, b, acc, clr_w);
    check("latency", n, 10);
    check("busy_cycles", nb, 9);
    check("result", 32'(bus.result), 32'(m_r));
    check("ovf", 32'(bus.ovf), 32'(m_o));
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 0);
    if (noise) watch_no_done("queued_start");
  endtask
  initial begin
    bus.start = 1'b0;
    bus.accumulate = 1'b0;
    bus.clr = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    rst = 1'b1;
    m_r = '0;
    m_o = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    rst = 1'b0;
    op(8'd13, 8'd11, 1'b0, 1'b0, 1'b0);
`ifndef MAC_SEQ_SIGNED_EN
    check("t1_result", 32'(bus.result), 143);
`endif
    op(8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
`ifndef MAC_SEQ_SIGNED_EN
    check("t2_result", 32'(bus.result), 65168);
`endif
    op(8'd255, 8'd255, 1'b1, 1'b1, 1'b0);
    repeat (16) op(8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
`ifndef MAC_SEQ_SIGNED_EN
    check("t3_result", 32'(bus.result), 56849);
    check("t3_ovf", 32'(bus.ovf), 1);
`endif
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    m_r = '0;
    m_o = 1'b0;
    check("clr_result", 32'(bus.result), 0);
    check("clr_ovf", 32'(bus.ovf), 0);
    op(8'd9, 8'd9, 1'b0, 1'b0, 1'b1);
    op(8'd2, 8'd3, 1'b1, 1'b1, 1'b0);
    check("t4_result", 32'(bus.result), 6);
    @(negedge clk);
    bus.start = 1'b1;
    bus.accumulate = 1'b1;
    bus.op_a = 8'd200;
    bus.op_b = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_r = '0;
    m_o = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_result", 32'(bus.result), 0);
    check("abort_ovf", 32'(bus.ovf), 0);
    watch_no_done("abort_no_done");
    op(8'd7, 8'd7, 1'b0, 1'b0, 1'b0);
    check("t5_result", 32'(bus.result), 49);
`ifdef MAC_SEQ_SIGNED_EN
    op(8'hFD, 8'd5, 1'b0, 1'b0, 1'b0);
    check("t6_neg", 32'(bus.result), 32'h000FFFF1);
    op(8'd3, 8'd5, 1'b1, 1'b0, 1'b0);
    check("t6_zero", 32'(bus.result), 0);
    check("t6_ovf", 32'(bus.ovf), 0);
`endif
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r = $urandom();
      op(r[7:0], r[15:8], r[16], r[19:17] == 3'd0, r[21:20] == 2'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequential shift-add multiply-accumulate controller for the mul_ace Tiny Tapeout design. It time-shares one WIDTH-bit adder across WIDTH iterations to form an unsigned product, then adds that product into, or loads it into, an ACC_W-bit accumulator. It sits under the tt_um top wrapper:
- operands come from `ui_in` and `uio_in`;
- control comes from latched pins;
- result bytes are muxed out to `uo_out`.

## Interface
Parameters:
- `WIDTH`, 8, operand width; also the iteration count.
- `ACC_W`, 20, accumulator width; must be ≥ 2·WIDTH.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `accumulate`  in  1  sampled with `start`: 1 = result += product, 0 = result = product.
- `clr`  in  1  clears `result` and `ovf`; honoured only in IDLE.
- `op_a`  in  WIDTH  multiplicand; captured on an accepted `start`.
- `op_b`  in  WIDTH  multiplier; captured on an accepted `start`.
- `busy`  out  1  high in ITER and ACC.
- `done`  out  1  one-cycle pulse; high only in DONE.
- `result`  out  ACC_W  accumulator value.
- `ovf`  out  1  sticky accumulator overflow flag.

## Operation
State machine:
- **IDLE**
  - `start`=1: capture `op_a`, `op_b` and `accumulate`; clear the partial product; set the counter to 0; go to ITER.
  - `start`=0: stay in IDLE.
- **ITER**, WIDTH cycles
  - If the multiplier LSB is 1, the upper partial-product half becomes upper half + multiplicand through the shared adder. The carry-out becomes the new MSB.
  - The {carry, partial, multiplier} register then shifts right by 1.
  - The counter increments. Go to ACC after count WIDTH-1.
- **ACC**
  - `accumulate`=1: `result` = `result` + zero-extended product, modulo 2^ACC_W. Carry-out sets `ovf`.
  - `accumulate`=0: `result` = product; `ovf` is unchanged.
  - Go to DONE.
- **DONE**: `done`=1 for one cycle; go to IDLE.

Boundary rules:
- `start` in ITER, ACC or DONE is ignored and is not queued.
- `clr` in IDLE clears `result` and `ovf` on the next edge.
- `clr` outside IDLE is ignored.
- `clr` and `start` together in IDLE: the clear takes effect and the operation is accepted. An accumulate then adds onto 0.
- `ovf` is cleared only by `rst` or `clr`.
- A zero operand still takes the full WIDTH iterations; there is no early termination.
- `rst` at any time, including mid-ITER:
  - next state IDLE;
  - `result`=0, `ovf`=0, `busy`=0, `done`=0;
  - no `done` pulse for the aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `ovf`=0, state IDLE.
- `start` is sampled at edge k.
- `busy` is high during cycles k+1 … k+WIDTH+1.
- `result` updates at edge k+WIDTH+1.
- `done` is high for the single cycle after edge k+WIDTH+1. For WIDTH=8 that is 10 cycles after the `start` edge.
- `result` is stable from the `done` cycle until the next ACC.
- Back-to-back operation: the earliest next `start` is sampled in the IDLE cycle following DONE. Throughput is one operation per WIDTH+3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- Macro `MAC_SEQ_SIGNED_EN`.
- **Defined:**
  - operands are two's complement;
  - magnitudes are multiplied unsigned;
  - in ACC the product is negated when the operand signs differ, then sign-extended to ACC_W;
  - `ovf` flags signed overflow: both addends the same sign and the sum a different sign.
- **Undefined:** fully unsigned behaviour as described above; no sign logic is synthesised.

## Structure
- Package `mac_seq_pkg`:
  - state enum `mac_state_t` {IDLE, ITER, ACC, DONE};
  - default constants `MAC_WIDTH`=8 and `MAC_ACC_W`=20;
  - counter width `$clog2(MAC_WIDTH)`.
- Sub-module `mac_seq_adder`: the shared WIDTH-bit adder with carry-out. It is the only arithmetic resource used in ITER.
- The ACC add is a separate ACC_W-bit adder inside `mac_seq_ctrl`.

## Test plan
All scenarios use WIDTH=8, ACC_W=20.
1. Reset, then `start` with `op_a`=13, `op_b`=11, `accumulate`=0 → `done` exactly 10 cycles after the start edge; `result`=143, `ovf`=0; `busy` high for 9 cycles.
2. Continuing from 1, `start` with 255×255, `accumulate`=1 → `result`=65168, `ovf`=0.
3. `clr`, then 17 accumulating 255×255 operations → `result`=56849, `ovf`=1. A following `clr` gives `result`=0, `ovf`=0.
4. `start` pulsed during ITER → ignored; exactly one `done`. `clr` and `start` together with 2×3, `accumulate`=1, on a nonzero `result` → `result`=6.
5. `rst` asserted in the 4th ITER cycle → next cycle `busy`=0, `result`=0; no `done` pulse; a new 7×7 then gives 49.
6. With `MAC_SEQ_SIGNED_EN`: `op_a`=-3 (0xFD), `op_b`=5, `accumulate`=0 → `result`=0xFFFF1; then accumulate 3×5 → `result`=0, `ovf`=0.
